// File: rtl/booth_div_pkg.sv
// Shared widths and state encoding for the sequential signed divider.
package booth_div_pkg;
    localparam int DIV_N = 4;
    localparam int QW    = 2 * DIV_N;
    localparam int RW    = DIV_N + 1;
    localparam int CW    = $clog2(2 * DIV_N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;
endpackage

// File: rtl/booth_divider_if.sv
// Request/result bundle between a requester and booth_divider.
interface booth_divider_if;
    import booth_div_pkg::*;

    logic                start;
    logic [QW-1:0]       dividend;
    logic [DIV_N-1:0]    divisor;
    logic [QW-1:0]       quotient;
    logic [DIV_N-1:0]    remainder;
    logic                busy;
    logic                done;
    logic                dbz;
    logic                ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dbz, ovf
    );
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dbz, ovf
    );
endinterface

// File: rtl/booth_divider_div_step.sv
// One restoring shift-subtract step on magnitudes: next partial remainder and quotient bit.
module div_step
    import booth_div_pkg::*;
(
    input  logic [RW-1:0]    r,
    input  logic             q_msb,
    input  logic [DIV_N-1:0] d,
    output logic [RW-1:0]    r_next,
    output logic             q_bit
);
    logic [RW-1:0] sh;
    logic [RW-1:0] diff;

    assign sh     = {r[DIV_N-1:0], q_msb};
    assign diff   = sh - {1'b0, d};
    // Compare on the full shifted value so a stray top bit of r can never be lost.
    assign q_bit  = ({r, q_msb} >= {2'b00, d});
    assign r_next = q_bit ? diff : sh;
endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: 2N/N restoring division on magnitudes, one bit per clock, then sign fix.
module booth_divider
    import booth_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    booth_divider_if.slave  bus
);
    state_t            state;
    logic [QW-1:0]     q;
    logic [RW-1:0]     r;
    logic [DIV_N-1:0]  d;
    logic [CW-1:0]     cnt;
    logic              sign_q, sign_r, dbz_p, ovf_p;

    logic [QW-1:0]     quotient, dvd_mag;
    logic [DIV_N-1:0]  remainder, dvs_mag;
    logic              busy, done, dbz, ovf;
    logic [QW:0]       dvd_ext;
    logic [DIV_N:0]    dvs_ext;
    logic [RW-1:0]     r_next;
    logic              q_bit;

    // One extra bit so |-2^(2N-1)| and |-2^(N-1)| are representable before narrowing.
    assign dvd_ext = {bus.dividend[QW-1], bus.dividend};
    assign dvs_ext = {bus.divisor[DIV_N-1], bus.divisor};
    assign dvd_mag = dvd_ext[QW]    ? QW'(-dvd_ext)    : QW'(dvd_ext);
    assign dvs_mag = dvs_ext[DIV_N] ? DIV_N'(-dvs_ext) : DIV_N'(dvs_ext);

    div_step u_step (
        .r      (r),
        .q_msb  (q[QW-1]),
        .d      (d),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= '0;
            r         <= '0;
            d         <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz_p     <= 1'b0;
            ovf_p     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        q      <= dvd_mag;
                        d      <= dvs_mag;
                        r      <= '0;
                        sign_q <= bus.dividend[QW-1] ^ bus.divisor[DIV_N-1];
                        sign_r <= bus.dividend[QW-1];
                        cnt    <= CW'(QW);
                        busy   <= 1'b1;
                        dbz_p  <= (bus.divisor == '0);
                        ovf_p  <= (bus.dividend == {1'b1, {(QW-1){1'b0}}}) &&
                                  (bus.divisor == '1);
                        state  <= (bus.divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    q   <= {q[QW-2:0], q_bit};
                    r   <= r_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    if (dbz_p) begin
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        quotient  <= sign_q ? -q : q;
                        remainder <= sign_r ? -r[DIV_N-1:0] : r[DIV_N-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    dbz   <= dbz_p;
                    ovf   <= ovf_p;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.dbz       = dbz;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_booth_divider.sv
// Directed and random checks of booth_divider against plain integer division.
module tb_booth_divider;
    import booth_div_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    booth_divider_if bus ();

    booth_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: C-style truncating division, quotient wrapped to QW bits.
    task automatic ref_div(input int a, input int b, output int q, output int r,
                           output int dz, output int ov);
        int qq;
        if (b == 0) begin
            q = 0; r = 0; dz = 1; ov = 0;
        end else begin
            qq = a / b;
            r  = a % b;
            dz = 0;
            ov = (a == -(1 << (QW-1)) && b == -1) ? 1 : 0;
            if (qq >= (1 << (QW-1))) qq = qq - (1 << QW);
            q  = qq;
        end
    endtask

    // Issue a/b; optionally re-pulse start with ia/ib at busy cycle inj (0 = never).
    task automatic run_op(input string tag, input int a, input int b,
                          input int inj, input int ia, input int ib);
        int eq, er, edz, eov, cyc;
        ref_div(a, b, eq, er, edz, eov);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = QW'(a);
        bus.divisor  = DIV_N'(b);
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (inj != 0 && cyc == inj) begin
                bus.start    = 1'b1;
                bus.dividend = QW'(ia);
                bus.divisor  = DIV_N'(ib);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_busy_cyc"}, cyc, (edz != 0) ? 1 : QW + 1);
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_q"}, 32'($signed(bus.quotient)), eq);
        chk({tag, "_r"}, 32'($signed(bus.remainder)), er);
        chk({tag, "_dbz"}, 32'(bus.dbz), edz);
        chk({tag, "_ovf"}, 32'(bus.ovf), eov);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 0);
        chk({tag, "_q_hold"}, 32'($signed(bus.quotient)), eq);
    endtask

    initial begin
        int cyc, seen, a, b;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_q", 32'(bus.quotient), 0);
        chk("rst_r", 32'(bus.remainder), 0);
        chk("rst_dbz", 32'(bus.dbz), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);

        run_op("p21_3", 21, 3, 0, 0, 0);
        run_op("m21_3", -21, 3, 0, 0, 0);
        run_op("p22_m5", 22, -5, 0, 0, 0);
        run_op("m22_5", -22, 5, 0, 0, 0);
        run_op("ovf", -128, -1, 0, 0, 0);
        run_op("dbz", 5, 0, 0, 0, 0);
        run_op("dbz_clr", 21, 3, 0, 0, 0);
        run_op("ignore", 100, 7, 3, 50, 5);
        run_op("m128_m8", -128, -8, 0, 0, 0);
        run_op("p127_m8", 127, -8, 0, 0, 0);

        // Async reset part-way through 100/7.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = QW'(100);
        bus.divisor  = DIV_N'(7);
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (bus.busy && cyc < 5) begin
            cyc++;
            if (cyc < 5) @(negedge clk);
        end
        chk("rstmid_reached", cyc, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(bus.busy), 0);
        chk("rstmid_done", 32'(bus.done), 0);
        chk("rstmid_q", 32'(bus.quotient), 0);
        chk("rstmid_r", 32'(bus.remainder), 0);
        chk("rstmid_dbz", 32'(bus.dbz), 0);
        chk("rstmid_ovf", 32'(bus.ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("rstmid_no_done", seen, 0);
        run_op("post_rst", 21, 3, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 15)) - 8;
            run_op($sformatf("rnd%0d", i), a, b, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
